// File: rtl/fifo_key_conditioner.sv
// Key/switch input conditioner for the 4-bit x 128 FIFO: synchronise, debounce, one-clock request pulses.
// Optional auto-repeat while a key is held is enabled by defining KEY_REPEAT_EN.
module fifo_key_conditioner #(
   parameter int WIDTH          = 4,
   parameter int TICK_DIV       = 50000,
   parameter int DEBOUNCE_TICKS = 20,
   parameter int REPEAT_DELAY   = 500,
   parameter int REPEAT_PERIOD  = 200
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             key_read_n,
   input  logic             key_write_n,
   input  logic [WIDTH-1:0] switch_in,
   output logic             read_req,
   output logic             write_req,
   output logic [WIDTH-1:0] data_out,
   output logic             key_busy
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_TICKS - 1);
   // An illegal parameter set never produces a tick, so the keys stay inert.
   localparam bit CFG_OK = (TICK_DIV >= 2) && (DEBOUNCE_TICKS >= 1) &&
                           (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

   typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} key_state_t;

   logic [1:0]       key_p0, key_p1;   // bit 0 = read key, bit 1 = write key
   logic [WIDTH-1:0] sw_p0, sw_p1;
   logic [PW-1:0]    pre_cnt;
   logic             tick;
   key_state_t       state [2];
   logic [CW-1:0]    cnt   [2];
   logic [1:0]       req;

`ifdef KEY_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW      = $clog2(REP_MAX + 1);
   localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
   logic [RW-1:0] rep_cnt   [2];
   logic          rep_first [2];
`endif

   // stage p0 -> p1: two-flop synchronisers, released (all ones) at reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         key_p0 <= '1;
         key_p1 <= '1;
         sw_p0  <= '1;
         sw_p1  <= '1;
      end else begin
         key_p0 <= {key_write_n, key_read_n};
         key_p1 <= key_p0;
         sw_p0  <= switch_in;
         sw_p1  <= sw_p0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         pre_cnt <= '0;
      else if (pre_cnt == TICK_LAST)
         pre_cnt <= '0;
      else
         pre_cnt <= pre_cnt + 1'b1;
   end

   assign tick = CFG_OK && (pre_cnt == TICK_LAST);

   // stage p1 -> outputs: per-key debounce FSMs, request pulses and data latch
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 2; k++) begin
            state[k] <= IDLE;
            cnt[k]   <= '0;
`ifdef KEY_REPEAT_EN
            rep_cnt[k]   <= '0;
            rep_first[k] <= 1'b1;
`endif
         end
         req      <= '0;
         data_out <= '0;
      end else begin
         req <= '0;
         for (int k = 0; k < 2; k++) begin
`ifdef KEY_REPEAT_EN
            if (state[k] != HELD) begin
               rep_cnt[k]   <= '0;
               rep_first[k] <= 1'b1;
            end
`endif
            if (tick) begin
               case (state[k])
                  IDLE: begin
                     if (!key_p1[k]) begin
                        state[k] <= PRESS;
                        cnt[k]   <= CW'(1);
                     end
                  end
                  PRESS: begin
                     if (key_p1[k]) begin
                        state[k] <= IDLE;
                     end else if (cnt[k] >= DB_LAST) begin
                        state[k] <= HELD;
                        req[k]   <= 1'b1;
                        if (k == 1) data_out <= sw_p1;
                     end else begin
                        cnt[k] <= cnt[k] + 1'b1;
                     end
                  end
                  HELD: begin
                     if (key_p1[k]) begin
                        state[k] <= RELEASE;
                        cnt[k]   <= CW'(1);
                     end
`ifdef KEY_REPEAT_EN
                     else if (rep_cnt[k] >= (rep_first[k] ? RD_LAST : RP_LAST)) begin
                        req[k]       <= 1'b1;
                        rep_cnt[k]   <= '0;
                        rep_first[k] <= 1'b0;
                        if (k == 1) data_out <= sw_p1;
                     end else begin
                        rep_cnt[k] <= rep_cnt[k] + 1'b1;
                     end
`endif
                  end
                  RELEASE: begin
                     if (!key_p1[k])
                        state[k] <= HELD;
                     else if (cnt[k] >= DB_LAST)
                        state[k] <= IDLE;
                     else
                        cnt[k] <= cnt[k] + 1'b1;
                  end
                  default: state[k] <= IDLE;
               endcase
            end
         end
      end
   end

   assign read_req  = req[0];
   assign write_req = req[1];
   assign key_busy  = (state[0] == HELD) || (state[0] == RELEASE) ||
                      (state[1] == HELD) || (state[1] == RELEASE);

endmodule

// File: tb/tb_fifo_key_conditioner.sv
// Directed bench for fifo_key_conditioner with small tick/debounce parameters.
// Expectations follow KEY_REPEAT_EN the same way as the design build.
module tb_fifo_key_conditioner;

   logic       clock;
   logic       reset;
   logic       key_read_n;
   logic       key_write_n;
   logic [3:0] switch_in;
   logic       read_req;
   logic       write_req;
   logic [3:0] data_out;
   logic       key_busy;

   fifo_key_conditioner #(
      .WIDTH(4), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .REPEAT_DELAY(5), .REPEAT_PERIOD(2)
   ) dut (
      .clock(clock), .reset(reset), .key_read_n(key_read_n), .key_write_n(key_write_n),
      .switch_in(switch_in), .read_req(read_req), .write_req(write_req),
      .data_out(data_out), .key_busy(key_busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

`ifdef KEY_REPEAT_EN
   localparam int EXP_40 = 3;   // pulses at window clocks 12, 32, 40
   localparam int EXP_80 = 8;   // 12, 32, 40, 48, 56, 64, 72, 80
   localparam logic [3:0] EXP_T2_DATA = 4'h3;
`else
   localparam int EXP_40 = 1;
   localparam int EXP_80 = 1;
   localparam logic [3:0] EXP_T2_DATA = 4'h5;
`endif

   int total = 0;
   int bad   = 0;
   int since_rel, win;
   int rd_cnt, wr_cnt, rd_first, rd_second, wr_first;
   logic [3:0] wr_first_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clr();
      win = 0; rd_cnt = 0; wr_cnt = 0;
      rd_first = -1; rd_second = -1; wr_first = -1;
      wr_first_data = 4'hx;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         since_rel++;
         win++;
         if (read_req === 1'b1) begin
            rd_cnt++;
            if (rd_first < 0) rd_first = win;
            else if (rd_second < 0) rd_second = win;
         end
         if (write_req === 1'b1) begin
            wr_cnt++;
            if (wr_first < 0) begin
               wr_first = win;
               wr_first_data = data_out;
            end
         end
      end
   endtask

   // Next clock edge after this is a prescaler wrap + 1, i.e. tick edges fall at window clocks 4, 8, 12...
   task automatic align();
      while (since_rel % 4 != 0) step(1);
   endtask

   initial begin
      reset = 1'b0; key_read_n = 1'b1; key_write_n = 1'b1; switch_in = 4'hA;
      since_rel = 0;
      clr();
      #1;
      step(3);
      chk("t1_read_req", read_req, 0);
      chk("t1_write_req", write_req, 0);
      chk("t1_data_out", data_out, 4'h0);
      chk("t1_key_busy", key_busy, 0);
      reset = 1'b1; since_rel = 0;
      step(6);

      // write key held 40 clocks; switches change after the first pulse
      switch_in = 4'h5;
      step(3);
      align(); clr();
      key_write_n = 1'b0;
      step(28);
      switch_in = 4'h3;
      step(12);
      chk("t2_write_cnt", wr_cnt, EXP_40);
      chk("t2_write_first", wr_first, 12);
      chk("t2_first_data", wr_first_data, 4'h5);
      chk("t2_read_cnt", rd_cnt, 0);
      chk("t2_busy_held", key_busy, 1);
      chk("t2_data_held", data_out, EXP_T2_DATA);
      key_write_n = 1'b1; clr();
      step(4);
      chk("t2_busy_release", key_busy, 1);
      switch_in = 4'hC;
      step(16);
      chk("t2_busy_idle", key_busy, 0);
      chk("t2_data_hold", data_out, EXP_T2_DATA);
      chk("t2_no_write", wr_cnt, 0);

      // bouncing read key: never more than two tick samples per low phase
      clr();
      for (int i = 0; i < 6; i++) begin
         key_read_n = 1'b0; step(5);
         key_read_n = 1'b1; step(5);
      end
      step(20);
      chk("t3_read_cnt", rd_cnt, 0);
      chk("t3_busy", key_busy, 0);
      chk("t3_data", data_out, EXP_T2_DATA);

      // both keys pressed together
      switch_in = 4'h9;
      step(3);
      align(); clr();
      key_read_n = 1'b0; key_write_n = 1'b0;
      step(40);
      chk("t4_read_cnt", rd_cnt, EXP_40);
      chk("t4_write_cnt", wr_cnt, EXP_40);
      chk("t4_same_clock", rd_first, wr_first);
      chk("t4_first", wr_first, 12);
      chk("t4_data", wr_first_data, 4'h9);
      key_read_n = 1'b1; key_write_n = 1'b1;
      step(24);

      // reset in the middle of PRESS with the key still held across release
      switch_in = 4'h6;
      step(3);
      align(); clr();
      key_write_n = 1'b0;
      step(9);
      chk("t5_pre_reset_cnt", wr_cnt, 0);
      chk("t5_pre_reset_busy", key_busy, 0);
      reset = 1'b0;
      #1;
      chk("t5_reset_data", data_out, 4'h0);
      chk("t5_reset_write", write_req, 0);
      step(3);
      chk("t5_in_reset_write", write_req, 0);
      chk("t5_in_reset_busy", key_busy, 0);
      reset = 1'b1; since_rel = 0; clr();
      step(40);
      chk("t5_write_cnt", wr_cnt, EXP_40);
      chk("t5_write_first", wr_first, 12);
      chk("t5_data", wr_first_data, 4'h6);
      key_write_n = 1'b1;
      step(24);

      // long read hold: one pulse, or auto-repeat when enabled
      align(); clr();
      key_read_n = 1'b0;
      step(80);
      key_read_n = 1'b1;
      chk("t6_read_cnt", rd_cnt, EXP_80);
      chk("t6_read_first", rd_first, 12);
`ifdef KEY_REPEAT_EN
      chk("t6_read_second", rd_second, 32);
`else
      chk("t6_read_second", rd_second, -1);
`endif
      chk("t6_write_cnt", wr_cnt, 0);
      chk("t6_data", data_out, 4'h6);
      step(24);
      chk("t6_busy_end", key_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
